// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared register-file constants and write-back source ids.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int XLEN          = 32;
    localparam int REG_AW        = 5;
    localparam int NUM_REGS      = 32;
    localparam int N_SRC_DEFAULT = 3;

    // Fixed producer positions on the write-back source vector
    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_MDU = 2'd2
    } src_id_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : One-hot grant over a request vector. With WB_RR_EN defined
//                the search starts at the pointer and wraps; otherwise the
//                lowest requesting index always wins and no pointer exists.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]          req,
`ifdef WB_RR_EN
    input  logic [$clog2(N)-1:0]  ptr,
`endif
    output logic [N-1:0]          gnt
);

    localparam logic [N-1:0] C_ONE = N'(1);

`ifdef WB_RR_EN
    localparam int PW = $clog2(N);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;

    // Requests at or above the pointer go first; fall back to the whole
    // vector so the search wraps around to the low indices.
    always_comb begin
        w_mask = '0;
        for (int j = 0; j < N; j++) begin
            w_mask[j] = (PW'(j) >= ptr);
        end
        w_hi = req & w_mask;
        if (|w_hi) begin
            gnt = w_hi & (~w_hi + C_ONE);
        end else begin
            gnt = req & (~req + C_ONE);
        end
    end
`else
    // Isolate the lowest set request bit
    always_comb begin
        gnt = req & (~req + C_ONE);
    end
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Write-back arbiter for the 32x32 register file. Each result
//                producer owns a one-entry holding slot; one slot per cycle
//                is granted the write port. A busy vector tracks registers
//                with a write still outstanding so decode can stall.
//                Build option: WB_RR_EN selects round-robin arbitration,
//                otherwise fixed priority (lowest index wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEFAULT,
    parameter int XLEN  = rf_pkg::XLEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    input  logic [N_SRC*REG_AW-1:0] src_addr,
    input  logic [N_SRC*XLEN-1:0]   src_data,
    output logic                    we,
    output logic [REG_AW-1:0]       WriteAddr,
    output logic [XLEN-1:0]         WriteData,
    input  logic                    issue_valid,
    input  logic [REG_AW-1:0]       issue_addr,
    output logic [NUM_REGS-1:0]     busy,
    output logic                    waw_err
);

    logic [N_SRC-1:0]    r_slot_full;
    logic [REG_AW-1:0]   r_slot_addr [N_SRC];
    logic [XLEN-1:0]     r_slot_data [N_SRC];
    logic [N_SRC-1:0]    w_grant;
    logic [REG_AW-1:0]   w_gnt_addr;
    logic [XLEN-1:0]     w_gnt_data;
    logic                w_we;
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic                w_waw;
    logic                r_waw_err;

    // A granted slot empties this edge, so it can take a new result at once
    assign src_ready = ~r_slot_full | w_grant;

    // Holding slots: load on handshake, release when granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_full <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                r_slot_addr[i] <= '0;
                r_slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    r_slot_full[i] <= 1'b1;
                    r_slot_addr[i] <= src_addr[i*REG_AW +: REG_AW];
                    r_slot_data[i] <= src_data[i*XLEN +: XLEN];
                end else if (w_grant[i]) begin
                    r_slot_full[i] <= 1'b0;
                end
            end
        end
    end

`ifdef WB_RR_EN
    localparam int PW = $clog2(N_SRC);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;

    // Pointer moves to the slot after the one just granted
    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_grant[i]) begin
                w_ptr_nxt = (i == N_SRC - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Arbitration pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    rr_arbiter #(
        .N   (N_SRC)
    ) u_arb (
        .req (r_slot_full),
        .ptr (r_ptr),
        .gnt (w_grant)
    );
`else
    rr_arbiter #(
        .N   (N_SRC)
    ) u_arb (
        .req (r_slot_full),
        .gnt (w_grant)
    );
`endif

    // Select the granted slot onto the write port; grant is one-hot so OR works
    always_comb begin
        w_gnt_addr = '0;
        w_gnt_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_grant[i]) begin
                w_gnt_addr = w_gnt_addr | r_slot_addr[i];
                w_gnt_data = w_gnt_data | r_slot_data[i];
            end
        end
    end

    // A granted x0 result drains silently; no grant leaves the address at 0
    assign w_we      = (w_gnt_addr != '0);
    assign we        = w_we;
    assign WriteAddr = w_gnt_addr;
    assign WriteData = w_we ? w_gnt_data : '0;

    // Busy set/clear decode and write-after-write detection
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_valid && (issue_addr != '0)) begin
            w_set[issue_addr] = 1'b1;
        end
        if (w_we) begin
            w_clr[w_gnt_addr] = 1'b1;
        end
        w_waw = issue_valid && r_busy[issue_addr] && !w_clr[issue_addr];
    end

    // Pending-write scoreboard; a same-cycle issue outranks the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= '0;
            r_waw_err <= 1'b0;
        end else begin
            r_busy    <= (r_busy & ~w_clr) | w_set;
            r_waw_err <= r_waw_err | w_waw;
        end
    end

    assign busy    = r_busy;
    assign waw_err = r_waw_err;

endmodule
`default_nettype wire
